// File: rtl/useq_pkg.sv
// Shared definitions for the useq microsequencer run controller: command ops,
// controller states and program-memory geometry.
package useq_pkg;

  localparam int USEQ_AW = 8;
  localparam int USEQ_DW = 8;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_WRITE  = 3'd1,
    OP_READ   = 3'd2,
    OP_RUN    = 3'd3,
    OP_HALT   = 3'd4,
    OP_STATUS = 3'd5
  } op_e;

  typedef enum logic {
    ST_HALTED  = 1'b0,
    ST_RUNNING = 1'b1
  } state_e;

  // STATUS byte layout: bit 7 = running, bit 0 = bounded run still has cycles left.
  function automatic logic [USEQ_DW-1:0] status_byte(input logic running, input logic cnt_nz);
    return {running, 6'b000000, cnt_nz};
  endfunction

endpackage

// File: rtl/useq_prog_ram.sv
// 256x8 program RAM: one synchronous write port, asynchronous host and core read ports.
module useq_prog_ram
  import useq_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [USEQ_AW-1:0] waddr,
  input  logic [USEQ_DW-1:0] wdata,
  input  logic [USEQ_AW-1:0] host_addr,
  output logic [USEQ_DW-1:0] host_data,
  input  logic [USEQ_AW-1:0] core_addr,
  output logic [USEQ_DW-1:0] core_data
);

  logic [USEQ_DW-1:0] mem_r [0:(1 << USEQ_AW) - 1];

  // Storage write; contents deliberately survive reset so programs persist.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign host_data = mem_r[host_addr];
  assign core_data = mem_r[core_addr];

endmodule

// File: rtl/useq_ctrl.sv
// Run controller for one useq core: owns the program RAM, gates the core reset
// for halt / free-run / bounded run, and serves a valid/ready host command channel.
module useq_ctrl
  import useq_pkg::*;
#(
  parameter int RUN_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [USEQ_AW-1:0]   cmd_addr,
  input  logic [RUN_CNT_W-1:0] cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [USEQ_DW-1:0]   rsp_data,
  output logic                 rsp_err,
  output logic                 core_rst_n,
  input  logic [USEQ_AW-1:0]   core_mem_addr,
  output logic [USEQ_DW-1:0]   core_mem_data,
  output logic                 running,
  output logic                 done
);

  localparam logic [RUN_CNT_W-1:0] CNT_ZERO = {RUN_CNT_W{1'b0}};
  localparam logic [RUN_CNT_W-1:0] CNT_ONE  = {{(RUN_CNT_W-1){1'b0}}, 1'b1};

  state_e                 state_r, next_state_s;
  logic [RUN_CNT_W-1:0]   cnt_r, cnt_next_s;
  logic                   rsp_valid_r, rsp_err_r, core_rst_n_r, done_r;
  logic [USEQ_DW-1:0]     rsp_data_r, rsp_data_next_s;
  logic                   rsp_err_next_s;
  logic                   accept_s, running_s, expire_s, wr_en_s;
  logic [USEQ_DW-1:0]     host_rd_data_s;
  op_e                    op_s;

  assign op_s      = op_e'(cmd_op);
  assign cmd_ready = !rsp_valid_r;
  assign accept_s  = cmd_valid && !rsp_valid_r;
  assign running_s = (state_r == ST_RUNNING);
  assign expire_s  = running_s && (cnt_r == CNT_ONE);

  useq_prog_ram u_ram (
    .clk       (clk),
    .we        (wr_en_s),
    .waddr     (cmd_addr),
    .wdata     (cmd_data[USEQ_DW-1:0]),
    .host_addr (cmd_addr),
    .host_data (host_rd_data_s),
    .core_addr (core_mem_addr),
    .core_data (core_mem_data)
  );

  // Next state, counter, RAM write enable and response payload; command decisions use the pre-edge state.
  always_comb begin
    next_state_s    = state_r;
    cnt_next_s      = cnt_r;
    wr_en_s         = 1'b0;
    rsp_data_next_s = 8'h00;
    rsp_err_next_s  = 1'b0;

    if (running_s && (cnt_r != CNT_ZERO)) begin
      cnt_next_s = cnt_r - CNT_ONE;
      if (expire_s) begin
        next_state_s = ST_HALTED;
      end else begin
        next_state_s = state_r;
      end
    end else begin
      cnt_next_s = cnt_r;
    end

    if (accept_s) begin
      case (op_s)
        OP_NOP: begin
          rsp_err_next_s = 1'b0;
        end
        OP_WRITE: begin
          if (running_s) begin
            rsp_err_next_s = 1'b1;
          end else begin
            wr_en_s = 1'b1;
          end
        end
        OP_READ: begin
          rsp_data_next_s = host_rd_data_s;
        end
        OP_RUN: begin
          // A run that expires on this same edge still counts as RUNNING: reject.
          if (running_s) begin
            rsp_err_next_s = 1'b1;
          end else begin
            next_state_s = ST_RUNNING;
            cnt_next_s   = cmd_data;
          end
        end
        OP_HALT: begin
          next_state_s = ST_HALTED;
          cnt_next_s   = CNT_ZERO;
        end
        OP_STATUS: begin
          rsp_data_next_s = status_byte(running_s, cnt_r != CNT_ZERO);
        end
        default: begin
          rsp_err_next_s = 1'b1;
        end
      endcase
    end else begin
      rsp_err_next_s = 1'b0;
    end
  end

  // Controller state, counter, core reset gate, done pulse and held response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_HALTED;
      cnt_r        <= CNT_ZERO;
      core_rst_n_r <= 1'b0;
      done_r       <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_data_r   <= 8'h00;
      rsp_err_r    <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      cnt_r        <= cnt_next_s;
      core_rst_n_r <= (next_state_s == ST_RUNNING);
      done_r       <= expire_s;
      if (accept_s) begin
        rsp_valid_r <= 1'b1;
        rsp_data_r  <= rsp_data_next_s;
        rsp_err_r   <= rsp_err_next_s;
      end else if (rsp_valid_r && rsp_ready) begin
        rsp_valid_r <= 1'b0;
        rsp_data_r  <= 8'h00;
        rsp_err_r   <= 1'b0;
      end
    end
  end

  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rsp_data_r;
  assign rsp_err    = rsp_err_r;
  assign core_rst_n = core_rst_n_r;
  assign running    = running_s;
  assign done       = done_r;

endmodule
